// File: rtl/complex_addsub_pipe.sv
// -----------------------------------------------------------------------------
// complex_addsub_pipe
//
// Two-stage pipelined complex adder/subtractor with valid/ready handshaking.
// The real and imaginary halves each use their own W-bit adder forming X + Y',
// where Y' = Y for add and ~Y with carry-in 1 for subtract. The result is optionally
// saturated on signed overflow. Per-result carry and overflow flags are
// delivered with the result, and overflow is accumulated into sticky bits
// on each output transfer.
//
// Ports:
//   CLK        in   1    clock, rising edge
//   RST_N      in   1    asynchronous active-low reset
//   IN_VALID   in   1    operands and mode valid
//   IN_READY   out  1    block accepts operands this cycle
//   IN_MODE    in   1    0 = A+B, 1 = A-B
//   A, B       in   2W   complex operands {real[2W-1:W], imag[W-1:0]}
//   OUT_VALID  out  1    result valid
//   OUT_READY  in   1    downstream accepts result
//   R          out  2W   complex result, same packing as A
//   OUT_CARRY  out  2    {real, imag} unsigned carry-out of the W-bit adder
//   OUT_OVF    out  2    {real, imag} signed overflow of this result
//   CLR_OVF    in   1    synchronous clear of OVF_STICKY
//   OVF_STICKY out  2    {real, imag} overflow accumulated since last clear
// -----------------------------------------------------------------------------
module complex_addsub_pipe #(
    parameter int unsigned W   = 16,
    parameter bit          SAT = 1'b1
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic           IN_MODE,
    input  logic [2*W-1:0] A,
    input  logic [2*W-1:0] B,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [2*W-1:0] R,
    output logic [1:0]     OUT_CARRY,
    output logic [1:0]     OUT_OVF,
    input  logic           CLR_OVF,
    output logic [1:0]     OVF_STICKY
);

    // Returns {ovf, carry, wrapped_sum[W-1:0]} for one component.
    function automatic logic [W+1:0] addsub_w(input logic signed [W-1:0] x,
                                              input logic signed [W-1:0] y,
                                              input logic                sub);
        logic [W-1:0] y_eff;
        logic [W:0]   sum;
        logic         ovf;
        y_eff = sub ? ~y : y;
        sum   = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, sub};
        // Overflow: adder inputs share a sign but the result sign differs.
        ovf   = (x[W-1] == y_eff[W-1]) && (sum[W-1] != x[W-1]);
        return {ovf, sum};
    endfunction

    // Clamp toward the sign of X when overflow occurred and saturation is on.
    function automatic logic signed [W-1:0] sat_w(input logic                ovf,
                                                  input logic                x_neg,
                                                  input logic signed [W-1:0] wrapped);
        if ((SAT != 1'b0) && ovf) begin
            return x_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return wrapped;
    endfunction

    logic           en;

    logic           vld_p1_q, vld_p1_d;
    logic [2*W-1:0] a_p1_q, a_p1_d;
    logic [2*W-1:0] b_p1_q, b_p1_d;
    logic           mode_p1_q, mode_p1_d;

    logic           vld_p2_q, vld_p2_d;
    logic [2*W-1:0] r_p2_q, r_p2_d;
    logic [1:0]     carry_p2_q, carry_p2_d;
    logic [1:0]     ovf_p2_q, ovf_p2_d;

    logic [1:0]     sticky_q, sticky_d;

    logic [W+1:0]   re_res, im_res;

    assign re_res = addsub_w(a_p1_q[2*W-1:W], b_p1_q[2*W-1:W], mode_p1_q);
    assign im_res = addsub_w(a_p1_q[W-1:0],   b_p1_q[W-1:0],   mode_p1_q);

    // The whole pipe advances together; stalls only when a result is held.
    assign en = !vld_p2_q || OUT_READY;

    always_comb begin
        vld_p1_d   = vld_p1_q;
        a_p1_d     = a_p1_q;
        b_p1_d     = b_p1_q;
        mode_p1_d  = mode_p1_q;
        vld_p2_d   = vld_p2_q;
        r_p2_d     = r_p2_q;
        carry_p2_d = carry_p2_q;
        ovf_p2_d   = ovf_p2_q;

        if (en) begin
            vld_p1_d  = IN_VALID;
            a_p1_d    = A;
            b_p1_d    = B;
            mode_p1_d = IN_MODE;
            vld_p2_d  = vld_p1_q;
            // Result registers only move for real data so R stays meaningful.
            if (vld_p1_q) begin
                r_p2_d     = {sat_w(re_res[W+1], a_p1_q[2*W-1], re_res[W-1:0]),
                              sat_w(im_res[W+1], a_p1_q[W-1],   im_res[W-1:0])};
                carry_p2_d = {re_res[W], im_res[W]};
                ovf_p2_d   = {re_res[W+1], im_res[W+1]};
            end
        end

        // Set wins over clear when both happen in the same cycle.
        sticky_d = (sticky_q & ~{2{CLR_OVF}}) |
                   ((vld_p2_q && OUT_READY) ? ovf_p2_q : 2'b00);
    end

    // ---- stage 1: operand capture (data unreset, valid reset) ----
    always_ff @(posedge CLK) begin
        a_p1_q    <= a_p1_d;
        b_p1_q    <= b_p1_d;
        mode_p1_q <= mode_p1_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    // ---- stage 2: result, flags, and sticky overflow ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p2_q   <= 1'b0;
            r_p2_q     <= '0;
            carry_p2_q <= 2'b00;
            ovf_p2_q   <= 2'b00;
            sticky_q   <= 2'b00;
        end else begin
            vld_p2_q   <= vld_p2_d;
            r_p2_q     <= r_p2_d;
            carry_p2_q <= carry_p2_d;
            ovf_p2_q   <= ovf_p2_d;
            sticky_q   <= sticky_d;
        end
    end

    assign IN_READY   = en;
    assign OUT_VALID  = vld_p2_q;
    assign R          = r_p2_q;
    assign OUT_CARRY  = carry_p2_q;
    assign OUT_OVF    = ovf_p2_q;
    assign OVF_STICKY = sticky_q;

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for complex_addsub_pipe. Two instances share the stimulus: one
// saturating (SAT=1) and one wrapping (SAT=0). A scoreboard queue receives the
// reference result at every accepted input and is compared at every output
// transfer; directed steps cover the fixed vectors, backpressure, sticky
// overflow and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_complex_addsub_pipe;
    localparam int W = 16;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          in_valid, in_mode, out_ready, clr_ovf;
    logic [2*W-1:0] a, b;

    logic          in_ready_s, out_valid_s, in_ready_w, out_valid_w;
    logic [2*W-1:0] r_s, r_w;
    logic [1:0]    carry_s, ovf_s, sticky_s, carry_w, ovf_w, sticky_w;

    always #5 CLK = ~CLK;

    complex_addsub_pipe #(.W(W), .SAT(1'b1)) u_sat (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(in_valid), .IN_READY(in_ready_s),
        .IN_MODE(in_mode), .A(a), .B(b), .OUT_VALID(out_valid_s),
        .OUT_READY(out_ready), .R(r_s), .OUT_CARRY(carry_s), .OUT_OVF(ovf_s),
        .CLR_OVF(clr_ovf), .OVF_STICKY(sticky_s));

    complex_addsub_pipe #(.W(W), .SAT(1'b0)) u_wrap (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(in_valid), .IN_READY(in_ready_w),
        .IN_MODE(in_mode), .A(a), .B(b), .OUT_VALID(out_valid_w),
        .OUT_READY(out_ready), .R(r_w), .OUT_CARRY(carry_w), .OUT_OVF(ovf_w),
        .CLR_OVF(clr_ovf), .OVF_STICKY(sticky_w));

    typedef struct {
        logic [31:0] r_sat;
        logic [31:0] r_wrap;
        logic [1:0]  carry;
        logic [1:0]  ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   out_cnt = 0;
    bit   chk_lat = 1'b0;
    logic [1:0] sticky_m = 2'b00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model using integer arithmetic on each component.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic mv, input int c);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            logic [15:0]        x, y;
            logic signed [15:0] xs, ys;
            int s, ux, uy;
            x  = av[16*k +: 16];
            y  = bv[16*k +: 16];
            xs = x;
            ys = y;
            ux = x;
            uy = y;
            s  = mv ? (int'(xs) - int'(ys)) : (int'(xs) + int'(ys));
            e.ovf[k]   = (s > 32767) || (s < -32768);
            e.carry[k] = mv ? (ux >= uy) : ((ux + uy) > 65535);
            e.r_wrap[16*k +: 16] = s[15:0];
            if (s > 32767)       e.r_sat[16*k +: 16] = 16'h7FFF;
            else if (s < -32768) e.r_sat[16*k +: 16] = 16'h8000;
            else                 e.r_sat[16*k +: 16] = s[15:0];
        end
        e.cyc = c;
        return e;
    endfunction

    // Monitor: sampled on the falling edge, describing the coming rising edge.
    always @(negedge CLK) begin
        exp_t e;
        logic [1:0] ovf_x;
        if (!RST_N) begin
            sb.delete();
            sticky_m = 2'b00;
        end else begin
            ovf_x = 2'b00;
            chk("sticky_sat", {62'd0, sticky_s}, {62'd0, sticky_m});
            chk("sticky_wrap", {62'd0, sticky_w}, {62'd0, sticky_m});
            if (out_valid_s && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {63'd0, out_valid_s}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("r_sat",   {32'd0, r_s},     {32'd0, e.r_sat});
                    chk("r_wrap",  {32'd0, r_w},     {32'd0, e.r_wrap});
                    chk("carry",   {62'd0, carry_s}, {62'd0, e.carry});
                    chk("ovf",     {62'd0, ovf_s},   {62'd0, e.ovf});
                    chk("ovf_wrap", {62'd0, ovf_w},  {62'd0, e.ovf});
                    chk("vld_wrap", {63'd0, out_valid_w}, 64'd1);
                    if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
                    ovf_x = e.ovf;
                    out_cnt = out_cnt + 1;
                end
            end
            sticky_m = (sticky_m & ~{2{clr_ovf}}) | ovf_x;
            if (in_valid && in_ready_s) begin
                sb.push_back(model(a, b, in_mode, cyc));
                acc_cnt = acc_cnt + 1;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic mv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        in_mode  = mv;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            step();
            k++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int base_a, base_o;
        logic [31:0] r_hold;
        exp_t e1;

        in_valid  = 1'b0;
        in_mode   = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;

        // Reset state while reset is held.
        step(2);
        chk("rst_out_valid", {63'd0, out_valid_s}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready_s},  64'd1);
        chk("rst_r",         {32'd0, r_s},         64'd0);
        chk("rst_carry",     {62'd0, carry_s},     64'd0);
        chk("rst_ovf",       {62'd0, ovf_s},       64'd0);
        chk("rst_sticky",    {62'd0, sticky_s},    64'd0);

        // Release and present the first operand immediately.
        RST_N = 1'b1;
        drive(32'h7FFF0001, 32'h00010001, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        chk("add_valid", {63'd0, out_valid_s}, 64'd1);
        chk("add_r_sat", {32'd0, r_s},         {32'd0, 32'h7FFF0002});
        chk("add_r_wrap", {32'd0, r_w},        {32'd0, 32'h80000002});
        chk("add_ovf",   {62'd0, ovf_s},       {62'd0, 2'b10});
        chk("add_carry", {62'd0, carry_s},     {62'd0, 2'b00});
        step();

        // Subtract with real overflow toward negative and real carry.
        drive(32'h80000000, 32'h0001FFFF, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        chk("sub_r_sat", {32'd0, r_s},     {32'd0, 32'h80000001});
        chk("sub_r_wrap", {32'd0, r_w},    {32'd0, 32'h7FFF0001});
        chk("sub_ovf",   {62'd0, ovf_s},   {62'd0, 2'b10});
        chk("sub_carry", {62'd0, carry_s}, {62'd0, 2'b10});
        step();
        chk("sticky_acc", {62'd0, sticky_s}, {62'd0, 2'b10});

        // Plain clear.
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("sticky_clr", {62'd0, sticky_s}, 64'd0);

        // Overflowing transfer coinciding with clear: set wins.
        drive(32'h7FFF0001, 32'h00010001, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        clr_ovf = 1'b1;
        step();
        chk("sticky_set_wins", {62'd0, sticky_s}, {62'd0, 2'b10});
        step();
        clr_ovf = 1'b0;
        chk("sticky_clr2", {62'd0, sticky_s}, 64'd0);

        // Backpressure: three operands offered, two accepted while stalled.
        out_ready = 1'b0;
        base_a = acc_cnt;
        e1 = model(32'h12345678, 32'h11110001, 1'b0, 0);
        drive(32'h12345678, 32'h11110001, 1'b0);
        step();
        drive(32'h40000000, 32'h40008000, 1'b0);
        step();
        drive(32'h00050005, 32'h00070003, 1'b1);
        chk("bp_in_ready", {63'd0, in_ready_s},  64'd0);
        chk("bp_valid",    {63'd0, out_valid_s}, 64'd1);
        r_hold = r_s;
        step(3);
        chk("bp_r_first", {32'd0, r_hold}, {32'd0, e1.r_sat});
        chk("bp_r_stable", {32'd0, r_s}, {32'd0, r_hold});
        chk("bp_in_ready2", {63'd0, in_ready_s}, 64'd0);
        chk("bp_accepted", 64'(acc_cnt - base_a), 64'd2);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        drain();
        chk("bp_accepted3", 64'(acc_cnt - base_a), 64'd3);

        // Streaming: 100 random operands back to back.
        chk_lat = 1'b1;
        base_o = out_cnt;
        for (int i = 0; i < 100; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
            step();
        end
        in_valid = 1'b0;
        drain();
        chk_lat = 1'b0;
        chk("stream_count", 64'(out_cnt - base_o), 64'd100);

        // Reset with both stages full.
        drive(32'h7FFF7FFF, 32'h00010001, 1'b0);
        step();
        drive(32'h01020304, 32'h05060708, 1'b1);
        step();
        chk("mid_full", {63'd0, out_valid_s}, 64'd1);
        RST_N    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid",  {63'd0, out_valid_s}, 64'd0);
        chk("mid_rst_ready",  {63'd0, in_ready_s},  64'd1);
        chk("mid_rst_sticky", {62'd0, sticky_s},    64'd0);
        step(2);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_idle", {63'd0, out_valid_s}, 64'd0);
        end
        base_o = out_cnt;
        drive(32'h00100020, 32'h00300040, 1'b0);
        step();
        in_valid = 1'b0;
        drain();
        chk("post_rst_out", 64'(out_cnt - base_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/complex_addsub_pipe.md
COMPLEX_ADDSUB_PIPE -- requirements
Module: complex_addsub_pipe

Interface
REQ-001 SHALL provide parameter W, default 16, width of each real/imaginary component (W >= 4).
REQ-002 SHALL provide parameter SAT, default 1: 1 = saturate on signed overflow, 0 = wrap.
REQ-003 SHALL have port CLK, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port IN_VALID, input, 1, operand pair and mode valid.
REQ-006 SHALL have port IN_READY, output, 1, block accepts operands this cycle.
REQ-007 SHALL have port IN_MODE, input, 1, 0 = A+B, 1 = A-B.
REQ-008 SHALL have port A, input, 2W, complex operand {real[2W-1:W], imag[W-1:0]}, two's complement.
REQ-009 SHALL have port B, input, 2W, complex operand, same packing as A.
REQ-010 SHALL have port OUT_VALID, output, 1, result valid.
REQ-011 SHALL have port OUT_READY, input, 1, downstream accepts result.
REQ-012 SHALL have port R, output, 2W, complex result, same packing as A.
REQ-013 SHALL have port OUT_CARRY, output, 2, {real, imag} unsigned carry-out of the W-bit adder.
REQ-014 SHALL have port OUT_OVF, output, 2, {real, imag} signed-overflow flag for this result.
REQ-015 SHALL have port CLR_OVF, input, 1, synchronous clear of OVF_STICKY.
REQ-016 SHALL have port OVF_STICKY, output, 2, {real, imag} accumulated overflow since last clear.

Function
REQ-017 SHALL implement two register stages: S1 captures A, B, IN_MODE; S2 holds the computed R, OUT_CARRY, OUT_OVF.
REQ-018 SHALL use pipeline advance enable EN = !OUT_VALID || OUT_READY; IN_READY = EN, combinational, with no dependence on IN_VALID.
REQ-019 SHALL accept a transfer when IN_VALID && IN_READY; S1 valid loads IN_VALID whenever EN = 1.
REQ-020 SHALL load S2 from S1 when EN = 1; OUT_VALID takes S1 valid; when EN = 0, all stages and outputs hold.
REQ-021 SHALL present each result two cycles after acceptance with no stall, sustain one result per cycle, and preserve order.
REQ-022 SHALL compute each component independently as X + Y', where Y' = Y for add and ~Y with carry-in 1 for subtract.
REQ-023 SHALL set OUT_CARRY per component to bit W of that unsigned (W+1)-bit sum.
REQ-024 SHALL set OUT_OVF per component when the operand signs into the adder (X, Y') match and the result sign differs.
REQ-025 SHALL, with SAT=1 and overflow, output 2^(W-1)-1 if X is non-negative, else -2^(W-1); with SAT=0, output the wrapped W-bit sum.
REQ-026 SHALL OR OUT_OVF into OVF_STICKY only on an output transfer (OUT_VALID && OUT_READY).
REQ-027 SHALL give set priority over clear when CLR_OVF coincides with an overflowing transfer, so that bit ends at 1.
REQ-028 SHALL hold R, OUT_CARRY and OUT_OVF stable while OUT_VALID = 1 and OUT_READY = 0.

Reset
REQ-029 SHALL, on RST_N low, immediately clear S1/S2 valid, OUT_VALID, R, OUT_CARRY, OUT_OVF and OVF_STICKY to 0.
REQ-030 SHALL drive IN_READY = 1 during and after reset (OUT_VALID = 0).
REQ-031 SHALL discard in-flight operands on reset mid-operation, so no stale result appears after release.
REQ-032 SHALL accept the first transfer on the first rising edge with RST_N high.

Verification
REQ-033 SHALL pass (W=16, SAT=1): A=0x7FFF0001, B=0x00010001, add -> after 2 cycles R=0x7FFF0002, OUT_OVF=10, OUT_CARRY=00; with SAT=0, R=0x80000002.
REQ-034 SHALL pass subtract: A=0x80000000, B=0x0001FFFF, SAT=1 -> R=0x80000001, OUT_OVF=10, OUT_CARRY=10.
REQ-035 SHALL pass backpressure: OUT_READY=0 with 3 operands offered back-to-back -> exactly 2 accepted, IN_READY=0, R stable; OUT_READY=1 -> 2 results in order, then 3rd accepted.
REQ-036 SHALL pass streaming: 100 random operands with OUT_READY=1 -> 100 results, each 2 cycles after its input, matching the reference model.
REQ-037 SHALL pass sticky: overflowing transfer with CLR_OVF=1 in the same cycle -> OVF_STICKY=10; CLR_OVF next cycle, no overflow -> 00.
REQ-038 SHALL pass reset mid-stream: RST_N low with S1 and S2 full -> OUT_VALID=0 immediately; after release, no output until a new input arrives.
